// File: rtl/div_16bit_seq.sv
// Multi-cycle 16-bit restoring divider: one quotient bit per cycle, 17-cycle latency,
// 1-cycle shortcut for divide-by-zero / signed overflow. Define DIV_SIGNED_EN for signed mode.
module div_16bit_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_op,
  input  logic [15:0] dividend,
  input  logic [15:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [15:0] quotient,
  output logic [15:0] remainder,
  output logic        ovfl,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] dvd_q, dvd_d;     // dividend shifts out MSB-first, quotient bits shift in
  logic [15:0] rem_q, rem_d;
  logic [15:0] dmag_q, dmag_d;
  logic [15:0] quo_q, quo_d;
  logic [15:0] remo_q, remo_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ovfl_q, ovfl_d;
  logic        dbz_q, dbz_d;

  logic [16:0] p, t;
  logic        qbit;
  logic [15:0] q_fin, r_fin;

`ifdef DIV_SIGNED_EN
  logic        negq_q, negq_d;
  logic        negr_q, negr_d;
`else
  logic        sgn_unused;
  assign sgn_unused = signed_op;
`endif

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    dmag_d  = dmag_q;
    quo_d   = quo_q;
    remo_d  = remo_q;
    cnt_d   = cnt_q;
    ovfl_d  = ovfl_q;
    dbz_d   = dbz_q;
`ifdef DIV_SIGNED_EN
    negq_d  = negq_q;
    negr_d  = negr_q;
`endif
    p     = {rem_q, dvd_q[15]};
    t     = p - {1'b0, dmag_q};
    qbit  = ~t[16];
    q_fin = {dvd_q[14:0], qbit};
    r_fin = qbit ? t[15:0] : p[15:0];

    case (state_q)
      IDLE: begin
        if (start) begin
          ovfl_d = 1'b0;
          dbz_d  = 1'b0;
          if (divisor == 16'h0) begin
            state_d = DONE;
            dbz_d   = 1'b1;
            remo_d  = dividend;
            quo_d   = 16'hFFFF;
`ifdef DIV_SIGNED_EN
            if (signed_op) quo_d = dividend[15] ? 16'h8000 : 16'h7FFF;
          end else if (signed_op && dividend == 16'h8000 && divisor == 16'hFFFF) begin
            state_d = DONE;
            quo_d   = 16'h7FFF;
            remo_d  = 16'h0;
            ovfl_d  = 1'b1;
`endif
          end else begin
            state_d = CALC;
            rem_d   = 16'h0;
            cnt_d   = 4'd0;
`ifdef DIV_SIGNED_EN
            negq_d  = signed_op & (dividend[15] ^ divisor[15]);
            negr_d  = signed_op & dividend[15];
            // |0x8000| stays 0x8000, read as unsigned magnitude
            dvd_d   = (signed_op && dividend[15]) ? 16'h0 - dividend : dividend;
            dmag_d  = (signed_op && divisor[15])  ? 16'h0 - divisor  : divisor;
`else
            dvd_d   = dividend;
            dmag_d  = divisor;
`endif
          end
        end
      end
      CALC: begin
        dvd_d = q_fin;
        rem_d = r_fin;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d = DONE;
          quo_d   = q_fin;
          remo_d  = r_fin;
`ifdef DIV_SIGNED_EN
          if (negq_q) quo_d  = 16'h0 - q_fin;
          if (negr_q) remo_d = 16'h0 - r_fin;
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dvd_q   <= 16'h0;
      rem_q   <= 16'h0;
      dmag_q  <= 16'h0;
      quo_q   <= 16'h0;
      remo_q  <= 16'h0;
      cnt_q   <= 4'd0;
      ovfl_q  <= 1'b0;
      dbz_q   <= 1'b0;
`ifdef DIV_SIGNED_EN
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      dmag_q  <= dmag_d;
      quo_q   <= quo_d;
      remo_q  <= remo_d;
      cnt_q   <= cnt_d;
      ovfl_q  <= ovfl_d;
      dbz_q   <= dbz_d;
`ifdef DIV_SIGNED_EN
      negq_q  <= negq_d;
      negr_q  <= negr_d;
`endif
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign quotient    = quo_q;
  assign remainder   = remo_q;
  assign ovfl        = ovfl_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_16bit_seq.sv
// Randomized bench for div_16bit_seq against a plain-arithmetic model of the divider.
module tb_div_16bit_seq;

  logic        clk = 1'b0;
  logic        rst, start, signed_op;
  logic [15:0] dividend, divisor;
  logic        busy, done, ovfl, div_by_zero;
  logic [15:0] quotient, remainder;

  div_16bit_seq dut (
    .clk(clk), .rst(rst), .start(start), .signed_op(signed_op),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .ovfl(ovfl), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        ov;
    logic        dz;
    int          lat;
  } exp_t;

  exp_t        expq[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  bit          mon_en = 1'b0;
  logic [15:0] h_q, h_r;
  logic        h_ov, h_dz;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic s);
    exp_t e;
    bit   se;
    int   sa, sb;
`ifdef DIV_SIGNED_EN
    se = s;
`else
    se = 1'b0;
`endif
    e.ov = 1'b0; e.dz = 1'b0; e.lat = 17;
    if (b == 16'h0) begin
      e.dz = 1'b1; e.lat = 1; e.r = a;
      e.q = se ? (a[15] ? 16'h8000 : 16'h7FFF) : 16'hFFFF;
    end else if (se && a == 16'h8000 && b == 16'hFFFF) begin
      e.q = 16'h7FFF; e.r = 16'h0; e.ov = 1'b1; e.lat = 1;
    end else if (se) begin
      sa = $signed(a); sb = $signed(b);
      e.q = 16'(sa / sb); e.r = 16'(sa % sb);
    end else begin
      e.q = a / b; e.r = a % b;
    end
    return e;
  endfunction

  task automatic set_reset_hold();
    h_q = 16'h0; h_r = 16'h0; h_ov = 1'b0; h_dz = 1'b0;
  endtask

  // Every cycle: while an op is outstanding, busy must be high and done must
  // arrive at exactly the model latency; otherwise the block is idle and holds.
  always @(negedge clk) begin
    if (mon_en) begin
      if (expq.size() > 0) begin
        cyc++;
        chk("busy_active", busy, 1);
        if (done) begin
          chk("latency", cyc, expq[0].lat);
          chk("quotient", quotient, expq[0].q);
          chk("remainder", remainder, expq[0].r);
          chk("ovfl", ovfl, expq[0].ov);
          chk("div_by_zero", div_by_zero, expq[0].dz);
          h_q = expq[0].q; h_r = expq[0].r; h_ov = expq[0].ov; h_dz = expq[0].dz;
          void'(expq.pop_front());
          cyc = 0;
        end else if (cyc >= expq[0].lat) begin
          chk("done_timeout", cyc, expq[0].lat - 1);
          void'(expq.pop_front());
          cyc = 0;
        end
      end else begin
        chk("busy_idle", busy, 0);
        chk("done_idle", done, 0);
        chk("hold_quotient", quotient, h_q);
        chk("hold_remainder", remainder, h_r);
        chk("hold_ovfl", ovfl, h_ov);
        chk("hold_dbz", div_by_zero, h_dz);
      end
    end
  end

  // mode 0: plain, 1: start pulse during CALC, 2: reset at CALC cycle 8, 3: start during DONE
  task automatic op(input logic [15:0] a, input logic [15:0] b, input logic s, input int mode);
    exp_t e;
    dividend = a; divisor = b; signed_op = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    e = model(a, b, s);
    expq.push_back(e);
    cyc = 0;
    for (int i = 0; i < 40 && expq.size() != 0; i++) begin
      dividend = 16'($urandom); divisor = 16'($urandom); signed_op = 1'($urandom);
      if (mode == 1 && i == 4) start = 1'b1;
      if (mode == 3 && i == e.lat - 1) start = 1'b1;
      if (mode == 2 && i == 7) rst = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (rst) begin
        rst = 1'b0;
        expq.delete();
        cyc = 0;
        set_reset_hold();
      end
    end
    chk("op_drained", expq.size(), 0);
    expq.delete();
  endtask

  task automatic pin(input string nm, input logic [15:0] a, input logic [15:0] b, input logic s,
                     input logic [15:0] q, input logic [15:0] r, input logic ov, input logic dz,
                     input int lat);
    exp_t e;
    e = model(a, b, s);
    chk({nm, "_q"}, e.q, q);
    chk({nm, "_r"}, e.r, r);
    chk({nm, "_flags"}, {e.ov, e.dz}, {ov, dz});
    chk({nm, "_lat"}, e.lat, lat);
  endtask

  initial begin
    logic [15:0] a, b;
    int          k;
    rst = 1'b1; start = 1'b0; signed_op = 1'b0; dividend = 16'h0; divisor = 16'h0;
    set_reset_hold();

    pin("m_u100_7",   16'd100,   16'd7,     1'b0, 16'd14,    16'd2,     1'b0, 1'b0, 17);
    pin("m_u8000",    16'h8000,  16'hFFFF,  1'b0, 16'h0,     16'h8000,  1'b0, 1'b0, 17);
    pin("m_udz",      16'h1234,  16'h0,     1'b0, 16'hFFFF,  16'h1234,  1'b0, 1'b1, 1);
    pin("m_uffff_1",  16'hFFFF,  16'h1,     1'b0, 16'hFFFF,  16'h0,     1'b0, 1'b0, 17);
    pin("m_u5_9",     16'd5,     16'd9,     1'b0, 16'h0,     16'd5,     1'b0, 1'b0, 17);
`ifdef DIV_SIGNED_EN
    pin("m_sneg100",  16'hFF9C,  16'd7,     1'b1, 16'hFFF2,  16'hFFFE,  1'b0, 1'b0, 17);
    pin("m_s100_n7",  16'd100,   16'hFFF9,  1'b1, 16'hFFF2,  16'd2,     1'b0, 1'b0, 17);
    pin("m_sovf",     16'h8000,  16'hFFFF,  1'b1, 16'h7FFF,  16'h0,     1'b1, 1'b0, 1);
    pin("m_sdz_pos",  16'h1234,  16'h0,     1'b1, 16'h7FFF,  16'h1234,  1'b0, 1'b1, 1);
    pin("m_sdz_neg",  16'hF000,  16'h0,     1'b1, 16'h8000,  16'hF000,  1'b0, 1'b1, 1);
`endif

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    op(16'd100,  16'd7,    1'b0, 0);
    op(16'hFF9C, 16'd7,    1'b1, 0);
    op(16'd100,  16'hFFF9, 1'b1, 0);
    op(16'h8000, 16'hFFFF, 1'b1, 0);
    op(16'h8000, 16'hFFFF, 1'b0, 0);
    op(16'h1234, 16'h0,    1'b1, 0);
    op(16'hF000, 16'h0,    1'b1, 0);
    op(16'h1234, 16'h0,    1'b0, 3);
    op(16'd1000, 16'd33,   1'b0, 1);
    op(16'd5000, 16'd17,   1'b0, 2);
    op(16'hFFFF, 16'h1,    1'b0, 3);
    op(16'd5,    16'd9,    1'b0, 0);
    repeat (3) @(posedge clk);
    #1;

    // reset and start on the same edge: reset wins, nothing is accepted
    rst = 1'b1; start = 1'b1; dividend = 16'd77; divisor = 16'd3;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    set_reset_hold();
    repeat (2) @(posedge clk);
    #1;

    for (int n = 0; n < 160; n++) begin
      k = $urandom_range(0, 9);
      a = 16'($urandom);
      b = 16'($urandom);
      if (k == 0) b = 16'h0;
      else if (k == 1) begin a = 16'h8000; b = 16'hFFFF; end
      else if (k == 2) b = 16'($urandom_range(1, 15));
      else if (k == 3) b = 16'hFFFF - 16'($urandom_range(0, 15));
      op(a, b, 1'($urandom), $urandom_range(0, 3));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
